mul_wb_arbiter: RTL
===================

Name: mul_wb_arbiter

Overview:
- Sits at the consumer end of the multiplier's output/stall interface. Merges multiplier results and the main ALU-path results into the single register-file writeback port, one instruction per cycle.
- Main-pipe (ALU) results get normal priority. Multiplier results are buffered in a small FIFO and drained into idle writeback slots.
- Back-pressure goes to the multiplier (`stall_mul_out`, wired to the multiplier's `stall_mul_in`) and to the main pipe (`stall_alu_out`).

Parameters:
- `DEPTH`, 2: multiplier result FIFO entries; must be >= 2.
- `CNT_W`, 32: width of the conflict performance counter.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-low reset (`rst` == 0 resets on posedge `clk`).
- `inst_mul_in` in `inst_decoded_t`: multiplier output; offered when `.valid & .reg_data_ready`.
- `stall_mul_out` out 1: multiplier must hold its output stage; the offer is not accepted this cycle.
- `inst_alu_in` in `inst_decoded_t`: main-pipe writeback candidate; offered when `.valid`.
- `stall_alu_out` out 1: main pipe must hold `inst_alu_in`; the offer is not accepted this cycle.
- `inst_wb_out` out `inst_decoded_t`: registered writeback instruction; writes when `.valid`.
- `conflict_cnt` out `CNT_W`: count of cycles with `stall_alu_out` = 1 while an ALU offer was present.

Behaviour:
- Reset (`rst` = 0):
  - FIFO count, read/write pointers and `conflict_cnt` all cleared to 0.
  - `inst_wb_out.valid` = 0 and `inst_wb_out.reg_data_ready` = 0; other fields don't-care.
  - `stall_mul_out` = 0 and `stall_alu_out` = 0 during reset.
  - Any FIFO contents are dropped; a reset mid-operation loses buffered results by design.
- Let `full` = (count == `DEPTH`). `stall_mul_out` = `full`; `stall_alu_out` = `full`. Both are combinational from count only and never depend on the input valids.
- Multiplier accept (`mul_acc`) = `inst_mul_in.valid` & `inst_mul_in.reg_data_ready` & !`full`. On accept, the full struct is written at the write pointer; the write pointer advances modulo `DEPTH`.
- ALU accept (`alu_acc`) = `inst_alu_in.valid` & !`full`.
- Drain (`deq`) = (count > 0) & (`full` | !`alu_acc`). The head is read at the read pointer; the read pointer advances modulo `DEPTH`.
- Output register selection, next cycle:
  - if `alu_acc`: `inst_wb_out` <= `inst_alu_in`;
  - else if `deq`: `inst_wb_out` <= FIFO head;
  - else `inst_wb_out.valid` <= 0.
  - The selected entry is forced to `.valid` = 1 and `.reg_data_ready` = 1. `dst_reg_data` and all other fields pass unchanged.
- No bypass. A multiplier result always enqueues, so minimum latency from multiplier accept to `inst_wb_out` is 2 cycles. ALU latency is 1 cycle.
- Count update: +1 on `mul_acc` & !`deq`; -1 on `deq` & !`mul_acc`; unchanged on both or neither. It never exceeds `DEPTH` and never goes below 0.
- When `full`: the head drains unconditionally, both inputs are stalled, and count becomes `DEPTH`-1 next cycle, so the stalls drop after exactly 1 cycle. This is the starvation guard for multiplier results.
- Ordering: multiplier results leave in acceptance order. ALU and multiplier results may reorder relative to each other; hazard tracking is upstream's job.
- `conflict_cnt` increments by 1 when `inst_alu_in.valid` & `stall_alu_out`, and wraps at 2^`CNT_W`.
- Write-pointer wrap and read-pointer wrap may occur in the same cycle.
- An offer made while stalled must be re-presented unchanged; the block does not latch it.

Test Plan:
- Reset: hold `rst` = 0 for 2 cycles with both inputs valid → `inst_wb_out.valid` = 0, both stalls 0, `conflict_cnt` = 0.
- ALU only: `inst_alu_in` valid with `dst_reg_data` = 0x0000_1234 → `inst_wb_out` valid with 0x1234 exactly 1 cycle later; stalls stay 0.
- Mul only: one mul offer with `dst_reg_data` = 0x0000_0042, ALU idle → `inst_wb_out.dst_reg_data` = 0x42 exactly 2 cycles after accept; count returns to 0.
- Conflict fill: ALU valid every cycle, 2 mul results (0xA, 0xB) on consecutive cycles →
  - count reaches 2 and both stalls assert;
  - 0xA is written while the ALU is held;
  - stalls drop the next cycle and `conflict_cnt` = 1;
  - 0xB drains on the next ALU-idle cycle.
- Simultaneous enq/deq: count = 1, ALU idle, new mul offer 0xC → head drains and 0xC enqueues in the same cycle; count stays 1 and order is preserved.
- Reset mid-operation: count = 2 with `rst` = 0 for 1 cycle → count 0, stalls 0, `inst_wb_out.valid` = 0; old entries never appear.

Source files
------------

// File: rtl/mul_wb_arbiter.sv
// Writeback arbiter: merges main-pipe (ALU) results with buffered multiplier results
// into a single registered register-file writeback port, one instruction per cycle.

package mul_wb_pkg;
    typedef struct packed {
        logic        valid;
        logic        reg_data_ready;
        logic [4:0]  dst_reg;
        logic [31:0] dst_reg_data;
    } inst_decoded_t;
endpackage

module mul_wb_arbiter
    import mul_wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  inst_decoded_t    inst_mul_in,
    output logic             stall_mul_out,
    input  inst_decoded_t    inst_alu_in,
    output logic             stall_alu_out,
    output inst_decoded_t    inst_wb_out,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    inst_decoded_t    fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count;

    logic          full;
    logic          mul_acc;
    logic          alu_acc;
    logic          deq;
    inst_decoded_t wb_sel;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full = (count == CW'(DEPTH));

    // Stalls depend on occupancy only; gated by reset so they read 0 while held in reset.
    assign stall_mul_out = full & rst;
    assign stall_alu_out = full & rst;

    always_comb begin
        mul_acc = inst_mul_in.valid & inst_mul_in.reg_data_ready & ~full;
        alu_acc = inst_alu_in.valid & ~full;
        // A full FIFO drains regardless of ALU traffic so multiplier results cannot starve.
        deq     = (count != '0) & (full | ~alu_acc);
        wb_sel  = alu_acc ? inst_alu_in : fifo_q[rd_ptr];
        wb_sel.valid          = 1'b1;
        wb_sel.reg_data_ready = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (mul_acc && rst) begin
            fifo_q[wr_ptr] <= inst_mul_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            conflict_cnt <= '0;
            inst_wb_out  <= '0;
        end else begin
            if (mul_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({mul_acc, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (alu_acc || deq) begin
                inst_wb_out <= wb_sel;
            end else begin
                inst_wb_out.valid <= 1'b0;
            end
            if (inst_alu_in.valid && stall_alu_out) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule
